// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the load/store sequencer.
package mem_access_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } mem_op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  function automatic logic is_store(mem_op_t op);
    return (op == OP_SW) || (op == OP_SH) ||
           (op == OP_SB);
  endfunction

  function automatic logic is_aligned(mem_op_t op,
                                      logic [1:0] a);
    logic ok;
    ok = 1'b1;
    unique case (op)
      OP_LW, OP_SW:         ok = (a == 2'b00);
      OP_LH, OP_LHU, OP_SH: ok = ~a[0];
      default:              ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_mux.sv
// Big-endian sub-word lane logic: load extract/extend
// and store read-modify-write merge.
module lane_mux
  import mem_access_pkg::*;
(
  input  mem_op_t     op_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] ld_o,
  output logic [31:0] st_o
);

  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] sb_w;
  logic [31:0] sh_w;

  always_comb begin
    b = word_i[31:24];
    sb_w = {wdata_i[7:0], word_i[23:0]};
    unique case (off_i)
      2'd1: begin
        b = word_i[23:16];
        sb_w = {word_i[31:24], wdata_i[7:0],
                word_i[15:0]};
      end
      2'd2: begin
        b = word_i[15:8];
        sb_w = {word_i[31:16], wdata_i[7:0],
                word_i[7:0]};
      end
      2'd3: begin
        b = word_i[7:0];
        sb_w = {word_i[31:8], wdata_i[7:0]};
      end
      default: ;
    endcase
  end

  assign h = off_i[1] ? word_i[15:0] : word_i[31:16];
  assign sh_w = off_i[1] ?
                {word_i[31:16], wdata_i[15:0]} :
                {wdata_i[15:0], word_i[15:0]};

  always_comb begin
    ld_o = word_i;
    st_o = wdata_i;
    unique case (op_i)
      OP_LH:   ld_o = {{16{h[15]}}, h};
      OP_LHU:  ld_o = {16'h0, h};
      OP_LB:   ld_o = {{24{b[7]}}, b};
      OP_LBU:  ld_o = {24'h0, b};
      OP_SB:   st_o = sb_w;
      OP_SH:   st_o = sh_w;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of the unified
// word-addressed memory; one request at a time.
module mem_access_unit
  import mem_access_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  input  logic [31:0] mem_rd
);

  state_t      state_q, state_d;
  mem_op_t     op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wd_q, wd_d;
  logic [31:0] word_q, word_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] lm_word;
  logic [31:0] ld_val;
  logic [31:0] st_val;
  mem_op_t     op_in;

  assign op_in = mem_op_t'(op);

  // READ extracts straight from memory; WRITE merges into the held word
  assign lm_word = (state_q == S_READ) ? mem_rd : word_q;

  lane_mux u_lane_mux (
    .op_i    (op_q),
    .off_i   (addr_q[1:0]),
    .word_i  (lm_word),
    .wdata_i (wd_q),
    .ld_o    (ld_val),
    .st_o    (st_val)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_LW;
      addr_q  <= '0;
      wd_q    <= '0;
      word_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    word_d  = word_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        state_d = S_IDLE;
        if (req) begin
          op_d   = op_in;
          addr_d = addr;
          wd_d   = wdata;
          if (!is_aligned(op_in, addr[1:0]))
            state_d = S_ERR;
          else if (op_in == OP_SW)
            state_d = S_WRITE;
          else
            state_d = S_READ;
        end
      end
      S_READ: begin
        word_d = mem_rd;
        if (is_store(op_q)) begin
          state_d = S_WRITE;
        end else begin
          state_d = S_DONE;
          rdata_d = ld_val;
        end
      end
      S_WRITE: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy   = (state_q == S_READ) ||
                  (state_q == S_WRITE);
  assign done   = (state_q == S_DONE) ||
                  (state_q == S_ERR);
  assign err    = (state_q == S_ERR);
  assign rdata  = rdata_q;
  assign mem_a  = {addr_q[31:2], 2'b00};
  assign mem_wd = st_val;
  // a reset arriving during WRITE must block that edge's write
  assign mem_we = (state_q == S_WRITE) & reset_n;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small
// word-addressed memory model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        busy, done, err, mem_we;
  logic [31:0] rdata, mem_a, mem_wd, mem_rd;

  logic [31:0] mem [0:63];
  int n_chk = 0;
  int n_pass = 0;
  int we_cnt = 0;
  int done_cnt = 0;
  int w0, d0;

  localparam logic [2:0] LW = 3'd0, LH = 3'd1,
    LHU = 3'd2, LB = 3'd3, LBU = 3'd4, SW = 3'd5,
    SH = 3'd6, SB = 3'd7;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .op      (op),
    .addr    (addr),
    .wdata   (wdata),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .rdata   (rdata),
    .mem_a   (mem_a),
    .mem_wd  (mem_wd),
    .mem_we  (mem_we),
    .mem_rd  (mem_rd)
  );

  assign mem_rd = mem[mem_a[7:2]];

  always @(posedge clk) begin
    if (mem_we) mem[mem_a[7:2]] <= mem_wd;
    if (mem_we) we_cnt <= we_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  tag, got, exp);
  endtask

  task automatic issue(input logic [2:0] o,
                       input logic [31:0] a,
                       input logic [31:0] wd);
    @(negedge clk);
    req = 1'b1; op = o; addr = a; wdata = wd;
    @(posedge clk);
  endtask

  task automatic do_load(input string tag,
                         input logic [2:0] o,
                         input logic [31:0] a,
                         input logic [31:0] exp);
    issue(o, a, 32'h0);
    @(negedge clk);
    req = 1'b0;
    chk({tag, "_busy"}, {31'h0, busy}, 32'd1);
    chk({tag, "_early"}, {31'h0, done}, 32'd0);
    @(negedge clk);
    chk({tag, "_done"}, {31'h0, done}, 32'd1);
    chk({tag, "_rdata"}, rdata, exp);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[16] = 32'h8899AABB;

    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_done", {31'h0, done}, 32'd0);
    chk("rst_err", {31'h0, err}, 32'd0);
    chk("rst_we", {31'h0, mem_we}, 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_wd", mem_wd, 32'h0);
    reset_n = 1'b1;

    do_load("lb41", LB, 32'h41, 32'hFFFFFF99);
    do_load("lbu43", LBU, 32'h43, 32'h000000BB);
    do_load("lh40", LH, 32'h40, 32'hFFFF8899);
    do_load("lhu42", LHU, 32'h42, 32'h0000AABB);
    do_load("lw40", LW, 32'h40, 32'h8899AABB);

    // SB then back-to-back LW
    w0 = we_cnt;
    issue(SB, 32'h42, 32'h12345677);
    @(negedge clk);
    req = 1'b0;
    chk("sb_rd_we", {31'h0, mem_we}, 32'd0);
    @(negedge clk);
    chk("sb_we", {31'h0, mem_we}, 32'd1);
    chk("sb_wd", mem_wd, 32'h889977BB);
    chk("sb_early", {31'h0, done}, 32'd0);
    @(negedge clk);
    chk("sb_done", {31'h0, done}, 32'd1);
    chk("sb_err", {31'h0, err}, 32'd0);
    chk("sb_keep", rdata, 32'h8899AABB);
    req = 1'b1; op = LW; addr = 32'h40;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    chk("b2b_busy", {31'h0, busy}, 32'd1);
    @(negedge clk);
    chk("b2b_done", {31'h0, done}, 32'd1);
    chk("b2b_rdata", rdata, 32'h889977BB);
    chk("sb_wecnt", we_cnt - w0, 32'd1);
    chk("sb_mem", mem[16], 32'h889977BB);

    // misaligned
    w0 = we_cnt;
    issue(SH, 32'h41, 32'hFFFF);
    @(negedge clk);
    req = 1'b0;
    chk("sh_done", {31'h0, done}, 32'd1);
    chk("sh_err", {31'h0, err}, 32'd1);
    chk("sh_we", {31'h0, mem_we}, 32'd0);
    issue(SW, 32'h42, 32'hCAFEF00D);
    @(negedge clk);
    req = 1'b0;
    chk("sw42_err", {31'h0, err}, 32'd1);
    chk("sw42_busy", {31'h0, busy}, 32'd0);
    @(negedge clk);
    chk("err_idle", {31'h0, done}, 32'd0);
    chk("err_wecnt", we_cnt - w0, 32'd0);
    chk("err_mem", mem[16], 32'h889977BB);
    chk("err_rdata", rdata, 32'h889977BB);

    // SW with a stray req during WRITE
    w0 = we_cnt;
    d0 = done_cnt;
    issue(SW, 32'h44, 32'hDEADBEEF);
    @(negedge clk);
    op = SW; addr = 32'h48; wdata = 32'h11111111;
    chk("sw_we", {31'h0, mem_we}, 32'd1);
    chk("sw_wd", mem_wd, 32'hDEADBEEF);
    chk("sw_a", mem_a, 32'h44);
    @(negedge clk);
    req = 1'b0;
    chk("sw_done", {31'h0, done}, 32'd1);
    @(negedge clk);
    chk("sw_idle", {31'h0, done | busy}, 32'd0);
    chk("sw_wecnt", we_cnt - w0, 32'd1);
    chk("sw_dcnt", done_cnt - d0, 32'd1);
    chk("sw_mem44", mem[17], 32'hDEADBEEF);
    chk("sw_mem48", mem[18], 32'h0);

    // reset during SB write
    w0 = we_cnt;
    d0 = done_cnt;
    issue(SB, 32'h40, 32'h00000055);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    chk("rw_state", {31'h0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rw_we", {31'h0, mem_we}, 32'd0);
    @(negedge clk);
    chk("rw_busy", {31'h0, busy}, 32'd0);
    chk("rw_done", {31'h0, done}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rw_idle", {31'h0, done | busy}, 32'd0);
    chk("rw_mem", mem[16], 32'h889977BB);
    chk("rw_wecnt", we_cnt - w0, 32'd0);
    chk("rw_dcnt", done_cnt - d0, 32'd0);
    chk("rw_rdata", rdata, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
